// File: rtl/mem_access_pkg.sv
// Shared encodings for the data memory access controller.
package mem_access_pkg;

  // Access size encodings as presented on cpu_size
  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;
  localparam logic [1:0] SIZE_ILL  = 2'b11;

  // Byte address of RAM word 0 unless overridden
  localparam logic [31:0] DEFAULT_BASE_ADDR = 32'h1001_0000;

  // Controller FSM states
  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_ACCESS = 2'b01,
    ST_MERGE  = 2'b10,
    ST_RESP   = 2'b11
  } state_e;

endpackage

// File: rtl/mem_lane_unit.sv
// Little-endian lane extraction/extension for loads and lane merge for
// sub-word stores. Purely combinational.
module mem_lane_unit
  import mem_access_pkg::*;
(
  input  logic [1:0]  offset_i,
  input  logic [1:0]  size_i,
  input  logic        unsigned_i,
  input  logic [31:0] old_word_i,
  input  logic [15:0] wdata_i,
  output logic [31:0] load_o,
  output logic [31:0] merged_o
);

  logic [4:0]  byte_sh_s;
  logic [4:0]  half_sh_s;
  logic [7:0]  byte_s;
  logic [15:0] half_s;

  // Select the addressed lane, extend it, and build the merged store word
  always_comb begin
    byte_sh_s = {offset_i, 3'b000};
    half_sh_s = {offset_i[1], 4'b0000};
    byte_s    = 8'(old_word_i >> byte_sh_s);
    half_s    = 16'(old_word_i >> half_sh_s);
    load_o    = 32'h0000_0000;
    merged_o  = old_word_i;
    case (size_i)
      SIZE_BYTE: begin
        if (unsigned_i) begin
          load_o = {24'h00_0000, byte_s};
        end else begin
          load_o = {{24{byte_s[7]}}, byte_s};
        end
        merged_o = (old_word_i & ~(32'h0000_00FF << byte_sh_s)) |
                   ({24'h00_0000, wdata_i[7:0]} << byte_sh_s);
      end
      SIZE_HALF: begin
        if (unsigned_i) begin
          load_o = {16'h0000, half_s};
        end else begin
          load_o = {{16{half_s[15]}}, half_s};
        end
        merged_o = (old_word_i & ~(32'h0000_FFFF << half_sh_s)) |
                   ({16'h0000, wdata_i} << half_sh_s);
      end
      SIZE_WORD: begin
        load_o   = old_word_i;
        merged_o = old_word_i;
      end
      default: begin
        load_o   = 32'h0000_0000;
        merged_o = old_word_i;
      end
    endcase
  end

endmodule

// File: rtl/data_mem_access_ctrl.sv
// Load/store access controller in front of a word-addressed single-port
// RAM. Sub-word stores are done as read-modify-write; illegal, misaligned
// and out-of-range requests are answered with an error without a RAM access.
module data_mem_access_ctrl
  import mem_access_pkg::*;
#(
  parameter int          DATA_WIDTH   = 32,
  parameter int          MEMORY_DEPTH = 64,
  parameter logic [31:0] BASE_ADDR    = DEFAULT_BASE_ADDR
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cpu_valid,
  output logic                  cpu_ready,
  input  logic                  cpu_we,
  input  logic [1:0]            cpu_size,
  input  logic                  cpu_unsigned,
  input  logic [DATA_WIDTH-1:0] cpu_addr,
  input  logic [DATA_WIDTH-1:0] cpu_wdata,
  output logic                  cpu_rvalid,
  output logic                  cpu_err,
  output logic [DATA_WIDTH-1:0] cpu_rdata,
  output logic                  ram_we,
  output logic [DATA_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_wdata,
  input  logic [DATA_WIDTH-1:0] ram_rdata
);

  localparam logic [DATA_WIDTH-1:0] RAM_BYTES = DATA_WIDTH'(4 * MEMORY_DEPTH);

  state_e                  state_q, state_d;
  logic                    ready_q, ready_d;
  logic                    rvalid_q, rvalid_d;
  logic                    err_q, err_d;
  logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
  logic                    ram_we_q, ram_we_d;
  logic [DATA_WIDTH-1:0]   ram_addr_q, ram_addr_d;
  logic [DATA_WIDTH-1:0]   ram_wdata_q, ram_wdata_d;

  logic                    we_q, we_d;
  logic [1:0]              size_q, size_d;
  logic                    uns_q, uns_d;
  logic [1:0]              off_q, off_d;
  logic [15:0]             wdata_q, wdata_d;

  logic [DATA_WIDTH-1:0]   rel_addr_s;
  logic                    req_err_s;
  logic [DATA_WIDTH-1:0]   load_val_s;
  logic [DATA_WIDTH-1:0]   merged_s;

  mem_lane_unit u_lane (
    .offset_i   (off_q),
    .size_i     (size_q),
    .unsigned_i (uns_q),
    .old_word_i (ram_rdata),
    .wdata_i    (wdata_q),
    .load_o     (load_val_s),
    .merged_o   (merged_s)
  );

  // Request legality: size, alignment and window check (unsigned wrap catches addr < base)
  always_comb begin
    rel_addr_s = cpu_addr - BASE_ADDR;
    req_err_s  = 1'b0;
    if (cpu_size == SIZE_ILL) begin
      req_err_s = 1'b1;
    end else if ((cpu_size == SIZE_HALF) && cpu_addr[0]) begin
      req_err_s = 1'b1;
    end else if ((cpu_size == SIZE_WORD) && (cpu_addr[1:0] != 2'b00)) begin
      req_err_s = 1'b1;
    end else if (rel_addr_s >= RAM_BYTES) begin
      req_err_s = 1'b1;
    end else begin
      req_err_s = 1'b0;
    end
  end

  // Next-state and next-output logic; outputs are computed one cycle ahead
  always_comb begin
    state_d     = state_q;
    ready_d     = ready_q;
    rvalid_d    = 1'b0;
    err_d       = 1'b0;
    rdata_d     = rdata_q;
    ram_we_d    = 1'b0;
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;
    we_d        = we_q;
    size_d      = size_q;
    uns_d       = uns_q;
    off_d       = off_q;
    wdata_d     = wdata_q;
    case (state_q)
      ST_IDLE: begin
        if (cpu_valid && ready_q) begin
          we_d    = cpu_we;
          size_d  = cpu_size;
          uns_d   = cpu_unsigned;
          off_d   = cpu_addr[1:0];
          wdata_d = cpu_wdata[15:0];
          rdata_d = '0;
          ready_d = 1'b0;
          if (req_err_s) begin
            state_d  = ST_RESP;
            rvalid_d = 1'b1;
            err_d    = 1'b1;
          end else begin
            state_d     = ST_ACCESS;
            ram_addr_d  = {cpu_addr[DATA_WIDTH-1:2], 2'b00};
            ram_wdata_d = cpu_wdata;
            ram_we_d    = cpu_we && (cpu_size == SIZE_WORD);
          end
        end else begin
          ready_d = 1'b1;
        end
      end
      ST_ACCESS: begin
        if (we_q && (size_q != SIZE_WORD)) begin
          // ram_rdata is the old word here; the merged word is written next cycle
          state_d     = ST_MERGE;
          ram_we_d    = 1'b1;
          ram_wdata_d = merged_s;
        end else if (we_q) begin
          state_d  = ST_RESP;
          rvalid_d = 1'b1;
        end else begin
          state_d  = ST_RESP;
          rvalid_d = 1'b1;
          rdata_d  = load_val_s;
        end
      end
      ST_MERGE: begin
        state_d  = ST_RESP;
        rvalid_d = 1'b1;
      end
      ST_RESP: begin
        state_d = ST_IDLE;
        ready_d = 1'b1;
      end
      default: begin
        state_d = ST_IDLE;
        ready_d = 1'b0;
      end
    endcase
  end

  // State, output and request-latch registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      ready_q     <= 1'b0;
      rvalid_q    <= 1'b0;
      err_q       <= 1'b0;
      rdata_q     <= '0;
      ram_we_q    <= 1'b0;
      ram_addr_q  <= BASE_ADDR;
      ram_wdata_q <= '0;
      we_q        <= 1'b0;
      size_q      <= SIZE_BYTE;
      uns_q       <= 1'b0;
      off_q       <= 2'b00;
      wdata_q     <= 16'h0000;
    end else begin
      state_q     <= state_d;
      ready_q     <= ready_d;
      rvalid_q    <= rvalid_d;
      err_q       <= err_d;
      rdata_q     <= rdata_d;
      ram_we_q    <= ram_we_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
      we_q        <= we_d;
      size_q      <= size_d;
      uns_q       <= uns_d;
      off_q       <= off_d;
      wdata_q     <= wdata_d;
    end
  end

  assign cpu_ready  = ready_q;
  assign cpu_rvalid = rvalid_q;
  assign cpu_err    = err_q;
  assign cpu_rdata  = rdata_q;
  assign ram_we     = ram_we_q;
  assign ram_addr   = ram_addr_q;
  assign ram_wdata  = ram_wdata_q;

endmodule

// File: tb/tb_data_mem_access_ctrl.sv
// Directed bench for data_mem_access_ctrl with a behavioural RAM and a
// scoreboard of expected responses.
module tb_data_mem_access_ctrl;

  localparam logic [31:0] BASE = 32'h1001_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        cpu_valid = 1'b0;
  logic        cpu_ready;
  logic        cpu_we = 1'b0;
  logic [1:0]  cpu_size = 2'b00;
  logic        cpu_unsigned = 1'b0;
  logic [31:0] cpu_addr = 32'h0;
  logic [31:0] cpu_wdata = 32'h0;
  logic        cpu_rvalid;
  logic        cpu_err;
  logic [31:0] cpu_rdata;
  logic        ram_we;
  logic [31:0] ram_addr;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata;

  logic [31:0] mem [64];
  logic [31:0] snap [64];
  int          wr_cnt = 0;
  int          checks = 0;
  int          errors = 0;

  typedef struct {
    string       tag;
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          writes;
  } exp_t;

  exp_t sb_q[$];

  data_mem_access_ctrl dut (
    .clk          (clk),
    .reset        (reset),
    .cpu_valid    (cpu_valid),
    .cpu_ready    (cpu_ready),
    .cpu_we       (cpu_we),
    .cpu_size     (cpu_size),
    .cpu_unsigned (cpu_unsigned),
    .cpu_addr     (cpu_addr),
    .cpu_wdata    (cpu_wdata),
    .cpu_rvalid   (cpu_rvalid),
    .cpu_err      (cpu_err),
    .cpu_rdata    (cpu_rdata),
    .ram_we       (ram_we),
    .ram_addr     (ram_addr),
    .ram_wdata    (ram_wdata),
    .ram_rdata    (ram_rdata)
  );

  always #5 clk = ~clk;

  // Combinational RAM read
  always_comb begin
    logic [31:0] rel;
    rel = (ram_addr - BASE) >> 2;
    if (rel < 32'd64) ram_rdata = mem[rel[5:0]];
    else              ram_rdata = 32'h0;
  end

  // RAM write and write counter
  always @(posedge clk) begin
    logic [31:0] rel;
    rel = (ram_addr - BASE) >> 2;
    if (ram_we) begin
      wr_cnt <= wr_cnt + 1;
      if (rel < 32'd64) mem[rel[5:0]] <= ram_wdata;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic req(input string tag, input logic we, input logic [1:0] size,
                     input logic uns, input logic [31:0] addr, input logic [31:0] wdata,
                     input logic [31:0] exp_rdata, input logic exp_err,
                     input int exp_lat, input int exp_wr);
    exp_t e;
    int   wr0;
    int   lat;
    bit   seen;
    sb_q.push_back('{tag: tag, rdata: exp_rdata, err: exp_err, lat: exp_lat, writes: exp_wr});
    @(negedge clk);
    chk({tag, "_ready"}, {31'h0, cpu_ready}, 32'h1);
    chk({tag, "_rvalid_idle"}, {31'h0, cpu_rvalid}, 32'h0);
    wr0 = wr_cnt;
    cpu_valid = 1'b1; cpu_we = we; cpu_size = size; cpu_unsigned = uns;
    cpu_addr = addr; cpu_wdata = wdata;
    @(posedge clk);
    @(negedge clk);
    cpu_valid = 1'b0;
    lat  = 1;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (cpu_rvalid) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
      lat++;
    end
    e = sb_q.pop_front();
    chk({e.tag, "_rvalid_seen"}, {31'h0, seen}, 32'h1);
    chk({e.tag, "_latency"}, 32'(lat), 32'(e.lat));
    chk({e.tag, "_err"}, {31'h0, cpu_err}, {31'h0, e.err});
    chk({e.tag, "_rdata"}, cpu_rdata, e.rdata);
    chk({e.tag, "_writes"}, 32'(wr_cnt - wr0), 32'(e.writes));
  endtask

  initial begin
    int diffs;
    // Reset values
    repeat (2) @(negedge clk);
    chk("rst_ready", {31'h0, cpu_ready}, 32'h0);
    chk("rst_rvalid", {31'h0, cpu_rvalid}, 32'h0);
    chk("rst_err", {31'h0, cpu_err}, 32'h0);
    chk("rst_rdata", cpu_rdata, 32'h0);
    chk("rst_ram_we", {31'h0, ram_we}, 32'h0);
    chk("rst_ram_wdata", ram_wdata, 32'h0);
    chk("rst_ram_addr", ram_addr, BASE);
    reset = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", {31'h0, cpu_ready}, 32'h1);

    // Word store / load
    req("sw_word", 1'b1, 2'b10, 1'b0, 32'h1001_0004, 32'hDEAD_BEEF, 32'h0, 1'b0, 2, 1);
    chk("mem1_word", mem[1], 32'hDEAD_BEEF);
    req("lw_word", 1'b0, 2'b10, 1'b0, 32'h1001_0004, 32'h0, 32'hDEAD_BEEF, 1'b0, 2, 0);

    // Byte read-modify-write and loads
    req("sw_pre", 1'b1, 2'b10, 1'b0, 32'h1001_0004, 32'h1122_3344, 32'h0, 1'b0, 2, 1);
    req("sb", 1'b1, 2'b00, 1'b0, 32'h1001_0006, 32'h0000_00A5, 32'h0, 1'b0, 3, 1);
    chk("mem1_sb", mem[1], 32'h11A5_3344);
    req("lb", 1'b0, 2'b00, 1'b0, 32'h1001_0006, 32'h0, 32'hFFFF_FFA5, 1'b0, 2, 0);
    req("lbu", 1'b0, 2'b00, 1'b1, 32'h1001_0006, 32'h0, 32'h0000_00A5, 1'b0, 2, 0);
    req("lbu_lane3", 1'b0, 2'b00, 1'b1, 32'h1001_0007, 32'h0, 32'h0000_0011, 1'b0, 2, 0);

    // Halfword read-modify-write and loads
    req("sw_zero", 1'b1, 2'b10, 1'b0, 32'h1001_0000, 32'h0, 32'h0, 1'b0, 2, 1);
    req("sh", 1'b1, 2'b01, 1'b0, 32'h1001_0002, 32'h0000_8001, 32'h0, 1'b0, 3, 1);
    chk("mem0_sh", mem[0], 32'h8001_0000);
    req("lh", 1'b0, 2'b01, 1'b0, 32'h1001_0002, 32'h0, 32'hFFFF_8001, 1'b0, 2, 0);
    req("lhu", 1'b0, 2'b01, 1'b1, 32'h1001_0002, 32'h0, 32'h0000_8001, 1'b0, 2, 0);
    repeat (3) @(negedge clk);
    chk("rdata_hold", cpu_rdata, 32'h0000_8001);

    // Alignment and illegal size
    req("lw_misal", 1'b0, 2'b10, 1'b0, 32'h1001_0002, 32'h0, 32'h0, 1'b1, 1, 0);
    req("lh_misal", 1'b0, 2'b01, 1'b0, 32'h1001_0001, 32'h0, 32'h0, 1'b1, 1, 0);
    req("size11", 1'b0, 2'b11, 1'b0, 32'h1001_0000, 32'h0, 32'h0, 1'b1, 1, 0);
    req("sw_misal", 1'b1, 2'b10, 1'b0, 32'h1001_0001, 32'h5555_5555, 32'h0, 1'b1, 1, 0);

    // Range boundaries
    req("sw_top", 1'b1, 2'b10, 1'b0, 32'h1001_00FC, 32'h1234_5678, 32'h0, 1'b0, 2, 1);
    chk("mem63", mem[63], 32'h1234_5678);
    for (int i = 0; i < 64; i++) snap[i] = mem[i];
    req("sw_above", 1'b1, 2'b10, 1'b0, 32'h1001_0100, 32'hBAD0_BAD0, 32'h0, 1'b1, 1, 0);
    req("sw_below", 1'b1, 2'b10, 1'b0, 32'h1000_FFFC, 32'hBAD1_BAD1, 32'h0, 1'b1, 1, 0);
    diffs = 0;
    for (int i = 0; i < 64; i++) if (mem[i] !== snap[i]) diffs++;
    chk("range_no_change", 32'(diffs), 32'h0);

    // Reset during the merge cycle of a byte store
    req("sw_rst_pre", 1'b1, 2'b10, 1'b0, 32'h1001_0008, 32'hCAFE_F00D, 32'h0, 1'b0, 2, 1);
    @(negedge clk);
    cpu_valid = 1'b1; cpu_we = 1'b1; cpu_size = 2'b00; cpu_unsigned = 1'b0;
    cpu_addr = 32'h1001_0009; cpu_wdata = 32'h0000_0077;
    @(posedge clk);
    @(negedge clk);
    cpu_valid = 1'b0;
    @(negedge clk);
    chk("merge_we", {31'h0, ram_we}, 32'h1);
    reset = 1'b0;
    #1;
    chk("rst_we_drop", {31'h0, ram_we}, 32'h0);
    chk("rst_addr", ram_addr, BASE);
    @(negedge clk);
    chk("rst_mem_kept", mem[2], 32'hCAFE_F00D);
    chk("rst_ready_low", {31'h0, cpu_ready}, 32'h0);
    reset = 1'b1;
    @(negedge clk);
    chk("rel_ready", {31'h0, cpu_ready}, 32'h1);
    req("lw_after_rst", 1'b0, 2'b10, 1'b0, 32'h1001_0008, 32'h0, 32'hCAFE_F00D, 1'b0, 2, 0);
    chk("sb_queue_empty", 32'(sb_q.size()), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/data_mem_access_ctrl.md
# data_mem_access_ctrl

Load/store access controller sitting directly upstream of the word-addressed single-port data RAM. It accepts byte, halfword and word load/store requests from the processor datapath. Sub-word stores become a read-modify-write sequence on the RAM; loaded lanes are extracted and sign- or zero-extended. Misaligned and out-of-range accesses are rejected without touching the RAM.

## Interface
- `DATA_WIDTH`, 32, width of data and address paths (only 32 supported).
- `MEMORY_DEPTH`, 64, number of words in the downstream RAM.
- `BASE_ADDR`, 32'h1001_0000, byte address of RAM word 0.
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `cpu_valid`  in  1  request present.
- `cpu_ready`  out  1  controller can accept; transfer on `cpu_valid && cpu_ready` at a rising edge.
- `cpu_we`  in  1  1 = store, 0 = load.
- `cpu_size`  in  2  00 byte, 01 halfword, 10 word, 11 illegal.
- `cpu_unsigned`  in  1  loads: 1 = zero-extend, 0 = sign-extend.
- `cpu_addr`  in  32  byte address.
- `cpu_wdata`  in  32  store data, right-aligned (lane in low bits).
- `cpu_rvalid`  out  1  one-cycle completion pulse (loads and stores).
- `cpu_err`  out  1  valid with `cpu_rvalid`: request rejected.
- `cpu_rdata`  out  32  load result; 0 for stores and errors.
- `ram_we`  out  1  RAM write enable.
- `ram_addr`  out  32  absolute byte address, bits [1:0] always 00.
- `ram_wdata`  out  32  word to write.
- `ram_rdata`  in  32  RAM combinational read data for `ram_addr`.

## Operation
- Little-endian lanes: byte at offset k is bits [8k+7:8k]; halfword at offset 0 is [15:0], at offset 2 is [31:16].
- FSM states: IDLE, ACCESS, MERGE, RESP.
- IDLE: `cpu_ready`=1. On accept, latch we/size/unsigned/addr/wdata and check the request:
  - Error if `cpu_size`==11.
  - Error if halfword with addr[0]=1.
  - Error if word with addr[1:0]≠0.
  - Error if (addr − BASE_ADDR) ≥ 4·MEMORY_DEPTH. The subtraction is unsigned 32-bit, so it also catches addr < BASE_ADDR.
  - On error: go to RESP with err flag set. Otherwise go to ACCESS.
- ACCESS: `ram_addr` = {addr[31:2],2'b00}.
  - Load: register the extracted, extended lane into `cpu_rdata`; go to RESP.
  - Word store: `ram_we`=1, `ram_wdata`=wdata; go to RESP.
  - Sub-word store: register `ram_rdata` as the old word; go to MERGE.
- MERGE: `ram_addr` unchanged, `ram_we`=1. `ram_wdata` = old word with the addressed lane replaced by wdata[7:0] or wdata[15:0]. Go to RESP.
- RESP: `cpu_rvalid`=1 and `cpu_err`=flag for exactly this cycle; go to IDLE.
- `cpu_ready`=0 outside IDLE. `cpu_valid` is ignored outside IDLE, and a request not accepted is not remembered.
- `ram_we` is 0 in IDLE, RESP, on error paths and for loads.
- `cpu_rdata` holds its value until the next accepted request.
- `cpu_rdata` is 0 for stores and errors.

## Timing
- Accept at edge E0:
  - Load: RESP (rvalid high) in the cycle after E1, i.e. 2 cycles after acceptance.
  - Word store: same as load; write occurs at E1.
  - Sub-word store: write occurs at E2, rvalid in the cycle after E2.
  - Error: rvalid in the cycle after E0.
- Back-to-back: the next request can be accepted at the edge ending RESP + 1 (first IDLE cycle).
- Reset low, asynchronously:
  - State forced to IDLE.
  - `cpu_rvalid`, `cpu_err`, `cpu_rdata`, `ram_we`, `ram_wdata` = 0; `ram_addr` = BASE_ADDR.
  - `cpu_ready`=0 while reset is low, and 1 from the first cycle after release.
- Reset during ACCESS or MERGE aborts the operation. `ram_we` drops immediately, and a pending sub-word merge is lost (RAM word unchanged).

## Structure
- Package `mem_access_pkg` holds:
  - size encodings (SIZE_BYTE, SIZE_HALF, SIZE_WORD);
  - the FSM state typedef;
  - default BASE_ADDR.
- One combinational sub-module, `mem_lane_unit`:
  - inputs: offset, size, unsigned, old word, store data;
  - outputs: extended load value and merged store word.
- Top level holds the FSM, request latch and range/alignment checks.

## Test plan
- Word: sw 0xDEADBEEF to 0x1001_0004, then lw 0x1001_0004 → rdata 0xDEADBEEF. rvalid 2 cycles after each accept, err=0.
- Byte: word 0x11223344 at 0x1001_0004, then sb 0x000000A5 to 0x1001_0006 → RAM word 0x11A53344, written at E2. Then lb 0x1001_0006 → 0xFFFFFFA5; lbu → 0x000000A5.
- Half: word 0 at 0x1001_0000, then sh 0x8001 to 0x1001_0002 → word 0x80010000. lh → 0xFFFF8001; lhu → 0x00008001.
- Alignment/illegal: each of the following → err=1 one cycle after accept, rdata 0, `ram_we` never asserted:
  - lw 0x1001_0002;
  - lh 0x1001_0001;
  - size 11.
- Range (DEPTH 64):
  - sw to 0x1001_00FC → accepted and written;
  - sw to 0x1001_0100 → err;
  - sw to 0x1000_FFFC → err;
  - neither erroring store changes any RAM word.
- Reset: assert reset during the MERGE cycle of an sb → `ram_we` falls immediately and the target word is unchanged. After release, `cpu_ready`=1 next cycle and a new lw completes normally.
